// File: rtl/pc_gen.sv
// pc_gen: IF-stage PC generator (seq/jump/beq/jr select, imem_ready stall, 1-deep pending redirect, misalign pulse); ports clk, rst_n, pc_write, pc_src, beq_target, jr_target, pc_4_id, offset, imem_ready -> pc, pc_plus, fetch_valid, redirect_pending, misalign; define PC_EXC_EN to add exc -> epc exception entry at EXC_VEC
module pc_gen #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int INC = 4,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h80000180)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] beq_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] pc_4_id,
  input  logic [WIDTH-5:0] offset,
  input  logic             imem_ready,
`ifdef PC_EXC_EN
  input  logic             exc,
  output logic [WIDTH-1:0] epc,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             fetch_valid,
  output logic             redirect_pending,
  output logic             misalign
);
  logic [WIDTH-1:0] raw, tgt, pend_target;
  logic pend_valid, redirect, unused_ok;
  always_comb begin
    raw = pc_src == 2'b01 ? {pc_4_id[WIDTH-1:WIDTH-4], offset} : pc_src == 2'b10 ? beq_target : jr_target;
    tgt = {raw[WIDTH-1:2], 2'b00};
  end
  assign redirect = |pc_src;
  assign pc_plus = pc + WIDTH'(INC);
  assign redirect_pending = pend_valid;
  assign unused_ok = &{1'b0, pc_4_id[WIDTH-5:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_VEC;
      pend_valid <= 1'b0;
      pend_target <= '0;
      fetch_valid <= 1'b0;
      misalign <= 1'b0;
`ifdef PC_EXC_EN
      epc <= '0;
`endif
    end else begin
      fetch_valid <= 1'b1;
      misalign <= redirect && |raw[1:0];
`ifdef PC_EXC_EN
      if (exc) begin
        epc <= pc;
        pc <= EXC_VEC;
        pend_valid <= 1'b0;
        misalign <= 1'b0;
      end else
`endif
      if (pc_write) begin
        if (redirect) begin
          pc <= tgt;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          pc <= pend_target;
          pend_valid <= 1'b0;
        end else if (imem_ready) pc <= pc_plus;
      end else if (redirect) begin
        pend_target <= tgt;
        pend_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector scoreboard bench for pc_gen
module tb_pc_gen;
  logic clk = 1'b0, rst_n = 1'b0, pc_write = 1'b0, imem_ready = 1'b0, exc = 1'b0;
  logic [1:0] pc_src = '0;
  logic [31:0] beq_target = '0, jr_target = '0, pc_4_id = '0;
  logic [27:0] offset = '0;
  logic [31:0] pc, pc_plus;
  logic fetch_valid, redirect_pending, misalign;
`ifdef PC_EXC_EN
  logic [31:0] epc;
`endif
  typedef struct {
    logic [31:0] pc;
    logic fv, pend, mis;
    logic [31:0] epc;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_miss = 0;
  always #5 clk = ~clk;
  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_src(pc_src),
    .beq_target(beq_target), .jr_target(jr_target), .pc_4_id(pc_4_id),
    .offset(offset), .imem_ready(imem_ready),
`ifdef PC_EXC_EN
    .exc(exc), .epc(epc),
`endif
    .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending), .misalign(misalign)
  );
  task automatic step(input logic [31:0] rn, pw, src, t, p4, off, rdy, ex, e_pc, fv, pd, ms, e_epc);
    rst_n = rn[0];
    pc_write = pw[0];
    pc_src = src[1:0];
    beq_target = src == 2 ? t : 32'hdead_bee0;
    jr_target = src == 3 ? t : 32'h0bad_0000;
    pc_4_id = p4;
    offset = off[27:0];
    imem_ready = rdy[0];
    exc = ex[0];
    sb.push_back('{e_pc, fv[0], pd[0], ms[0], e_epc});
    @(posedge clk);
    @(negedge clk);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin : chk
      exp_t e;
      logic ok;
      e = sb.pop_front();
      ok = pc === e.pc && pc_plus === e.pc + 32'd4 && fetch_valid === e.fv &&
           redirect_pending === e.pend && misalign === e.mis;
`ifdef PC_EXC_EN
      ok = ok && epc === e.epc;
`endif
      if (!ok) begin
        n_miss++;
        $display("FAIL vec%0d: got pc=%h plus=%h fv=%b pend=%b mis=%b, want pc=%h plus=%h fv=%b pend=%b mis=%b epc=%h",
                 n_vec, pc, pc_plus, fetch_valid, redirect_pending, misalign,
                 e.pc, e.pc + 32'd4, e.fv, e.pend, e.mis, e.epc);
      end
      n_vec++;
    end
  end
  initial begin
    //   rn pw src target        p4           off        rdy ex  pc            fv pd ms epc
    step(0, 0, 0, 0,            0,           0,          1,  0,  0,            0, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  4,            1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  8,            1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'hc,          1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'h10,         1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          0,  0,  'h10,         1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          0,  0,  'h10,         1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'h14,         1, 0, 0, 0);
    step(1, 1, 1, 0,            'h40000010,  'h0000100,  1,  0,  'h40000100,   1, 0, 0, 0);
    step(1, 1, 3, 'h103,        0,           0,          1,  0,  'h100,        1, 0, 1, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'h104,        1, 0, 0, 0);
    step(1, 0, 2, 'h200,        0,           0,          1,  0,  'h104,        1, 1, 0, 0);
    step(1, 0, 3, 'h300,        0,           0,          1,  0,  'h104,        1, 1, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'h300,        1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'h304,        1, 0, 0, 0);
    step(1, 0, 2, 'h400,        0,           0,          1,  0,  'h304,        1, 1, 0, 0);
    step(1, 1, 3, 'h500,        0,           0,          0,  0,  'h500,        1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'h504,        1, 0, 0, 0);
    step(1, 0, 3, 'h602,        0,           0,          1,  0,  'h504,        1, 1, 1, 0);
    step(1, 0, 0, 0,            0,           0,          1,  0,  'h504,        1, 1, 0, 0);
    step(0, 0, 0, 0,            0,           0,          1,  0,  0,            0, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  4,            1, 0, 0, 0);
    step(1, 0, 2, 'h700,        0,           0,          1,  0,  4,            1, 1, 0, 0);
    step(1, 1, 0, 0,            0,           0,          0,  0,  'h700,        1, 0, 0, 0);
    step(1, 1, 3, 'hfffffffc,   0,           0,          1,  0,  'hfffffffc,   1, 0, 0, 0);
    step(1, 1, 0, 0,            0,           0,          1,  0,  0,            1, 0, 0, 0);
    step(1, 0, 0, 0,            0,           0,          1,  0,  0,            1, 0, 0, 0);
`ifdef PC_EXC_EN
    step(1, 1, 3, 'h24,         0,           0,          1,  0,  'h24,         1, 0, 0, 0);
    step(1, 0, 2, 'h900,        0,           0,          1,  0,  'h24,         1, 1, 0, 0);
    step(1, 0, 0, 0,            0,           0,          1,  1,  'h80000180,   1, 0, 0, 'h24);
    step(1, 1, 0, 0,            0,           0,          1,  0,  'h80000184,   1, 0, 0, 'h24);
`endif
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
